// File: rtl/sram_1w1r_fifo_ctrl.sv
// rtl/sram_1w1r_fifo_ctrl.sv - valid/ready FIFO controller driving a 1W1R SRAM macro with a 2-entry output skid queue
// Optional flush input enabled by SRAM_FIFO_FLUSH_EN.
module sram_1w1r_fifo_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 28,
    parameter int NUM_WMASKS = 4,
    parameter int READ_LAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef SRAM_FIFO_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic [ADDR_WIDTH+1:0]   count,
    output logic                    sram_csb0,
    output logic [NUM_WMASKS-1:0]   sram_wmask0,
    output logic [ADDR_WIDTH-1:0]   sram_addr0,
    output logic [DATA_WIDTH-1:0]   sram_din0,
    output logic                    sram_csb1,
    output logic [ADDR_WIDTH-1:0]   sram_addr1,
    input  logic [DATA_WIDTH-1:0]   sram_dout1
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   sram_cnt;
    logic [1:0]            inflight;
    logic [1:0]            skid_cnt;
    logic [READ_LAT-1:0]   cap_vld;
    logic [DATA_WIDTH-1:0] skid0;
    logic [DATA_WIDTH-1:0] skid1;

    logic       clr;
    logic       push;
    logic       pop;
    logic       issue;
    logic       capture;
    logic [2:0] occ_after_pop;

`ifdef SRAM_FIFO_FLUSH_EN
    assign clr = rst | flush;
`else
    assign clr = rst;
`endif

    assign s_ready = (sram_cnt < DEPTH_C) & ~clr;
    assign push    = s_valid & s_ready;
    assign m_valid = (skid_cnt != 2'd0);
    assign m_data  = skid0;
    assign pop     = m_valid & m_ready;
    assign capture = cap_vld[READ_LAT-1];

    // Words still owed to the skid queue, assuming this cycle's pop frees a slot.
    assign occ_after_pop = {1'b0, skid_cnt} + {1'b0, inflight} - {2'b00, pop};
    assign issue         = (sram_cnt != '0) && (occ_after_pop < 3'd2) && !clr;

    assign sram_csb0   = ~push;
    assign sram_wmask0 = {NUM_WMASKS{push}};
    assign sram_addr0  = push ? wr_ptr : '0;
    assign sram_din0   = push ? s_data : '0;
    assign sram_csb1   = ~issue;
    assign sram_addr1  = issue ? rd_ptr : '0;

    assign count = {1'b0, sram_cnt} + (ADDR_WIDTH+2)'(inflight) + (ADDR_WIDTH+2)'(skid_cnt);

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            inflight <= '0;
            skid_cnt <= '0;
            cap_vld  <= '0;
            skid0    <= '0;
            skid1    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            sram_cnt <= sram_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
            inflight <= inflight + 2'(issue) - 2'(capture);
            skid_cnt <= skid_cnt + 2'(capture) - 2'(pop);

            // The macro's dout1 is only valid on the edge READ_LAT after issue.
            cap_vld[0] <= issue;
            for (int i = 1; i < READ_LAT; i++) begin
                cap_vld[i] <= cap_vld[i-1];
            end

            case ({capture, pop})
                2'b01: skid0 <= skid1;
                2'b10: begin
                    if (skid_cnt == 2'd0) skid0 <= sram_dout1;
                    else                  skid1 <= sram_dout1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid0 <= sram_dout1;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= sram_dout1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_1w1r_fifo_ctrl.sv
// tb/tb_sram_1w1r_fifo_ctrl.sv - scoreboard bench for sram_1w1r_fifo_ctrl with a behavioural SRAM
module tb_sram_1w1r_fifo_ctrl;

    localparam int DW    = 128;
    localparam int AW    = 5;
    localparam int DEPTH = 28;
    localparam int NWM   = 4;

    logic          clk = 0;
    logic          rst = 1;
    logic          flush = 0;
    logic          s_valid = 0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 0;
    logic [DW-1:0] m_data;
    logic [AW+1:0] count;
    logic          csb0, csb1;
    logic [NWM-1:0] wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout1 = '0;

    sram_1w1r_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                          .NUM_WMASKS(NWM), .READ_LAT(1)) dut (
        .clk(clk), .rst(rst),
`ifdef SRAM_FIFO_FLUSH_EN
        .flush(flush),
`endif
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count),
        .sram_csb0(csb0), .sram_wmask0(wmask0), .sram_addr0(addr0), .sram_din0(din0),
        .sram_csb1(csb1), .sram_addr1(addr1), .sram_dout1(dout1)
    );

    always #5 clk = ~clk;

    // Behavioural 1W1R macro: both ports sampled at the posedge, read data one edge later.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        for (int k = 0; k < NWM; k++) begin
            if (!csb0 && wmask0[k]) mem[addr0][k*(DW/NWM) +: (DW/NWM)] <= din0[k*(DW/NWM) +: (DW/NWM)];
        end
        if (!csb1) dout1 <= mem[addr1];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int popped   = 0;
    int pushed   = 0;
    bit started  = 0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: the reference is simply an ordered list of accepted-but-not-delivered words.
    always @(negedge clk) begin
        if (started) begin
            chk("count", DW'(count), DW'(exp_q.size()));
            if (!csb0 && !csb1) chk("no_collision", DW'(addr0 == addr1), '0);
            if (rst || flush) begin
                exp_q.delete();
            end else begin
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_on_empty", 1, 0);
                    end else begin
                        logic [DW-1:0] e;
                        e = exp_q.pop_front();
                        chk("m_data", m_data, e);
                        popped++;
                    end
                end
                if (s_valid && s_ready) begin
                    exp_q.push_back(s_data);
                    pushed++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        s_valid = 0;
        m_ready = 1;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 300) begin
            step();
            n++;
        end
        chk("drain_done", DW'(exp_q.size()), '0);
    endtask

    initial begin
        int idx;
        int n;
        int p0;
        logic [DW-1:0] a5;
        a5 = {(DW/8){8'hA5}};

        // Reset state
        step();
        started = 1;
        step();
        chk("rst_s_ready", DW'(s_ready), '0);
        chk("rst_csb0", DW'(csb0), 1);
        chk("rst_csb1", DW'(csb1), 1);
        chk("rst_m_valid", DW'(m_valid), '0);
        chk("rst_count", DW'(count), '0);
        rst = 0;

        // Single word: push at N, issue at N+1, m_valid after N+2
        s_valid = 1; s_data = a5; m_ready = 1;
        #1;
        chk("w_csb0", DW'(csb0), '0);
        chk("w_addr0", DW'(addr0), '0);
        chk("w_wmask", DW'(wmask0), DW'(4'hF));
        step();
        s_valid = 0;
        #1;
        chk("n0_csb0", DW'(csb0), 1);
        chk("n0_csb1", DW'(csb1), '0);
        chk("n0_addr1", DW'(addr1), '0);
        chk("n0_m_valid", DW'(m_valid), '0);
        step();
        chk("n1_m_valid", DW'(m_valid), '0);
        step();
        chk("n2_m_valid", DW'(m_valid), 1);
        chk("n2_m_data", m_data, a5);
        step();
        chk("n3_count", DW'(count), '0);
        chk("n3_m_valid", DW'(m_valid), '0);

        // Fill: DEPTH words in SRAM plus 2 prefetched into the skid queue
        m_ready = 0;
        idx = 0;
        n = 0;
        s_valid = 1;
        while (idx < DEPTH + 2 && n < 200) begin
            s_data = DW'(idx);
            @(negedge clk);
            if (s_ready) idx++;
            step();
            n++;
        end
        chk("fill_accepted", DW'(idx), DW'(DEPTH + 2));
        s_data = DW'(idx);
        repeat (3) step();
        chk("full_s_ready", DW'(s_ready), '0);
        chk("full_count", DW'(count), DW'(DEPTH + 2));
        chk("full_csb0", DW'(csb0), 1);
        drain();

        // Streaming: one word per clock, pointers wrap several times
        m_ready = 1;
        p0 = popped;
        s_valid = 1;
        for (int i = 0; i < 100; i++) begin
            s_data = rnd128();
            step();
        end
        s_valid = 0;
        step();
        step();
        @(negedge clk);
        #1;
        chk("stream_throughput", DW'(popped - p0), DW'(100));
        drain();

        // Reset mid-burst with 10 words stored
        m_ready = 0;
        s_valid = 1;
        for (int i = 0; i < 10; i++) begin
            s_data = rnd128();
            step();
        end
        s_valid = 0;
        repeat (3) step();
        chk("pre_rst_count", DW'(count), DW'(10));
        rst = 1;
        step();
        rst = 0;
        chk("mid_rst_m_valid", DW'(m_valid), '0);
        chk("mid_rst_count", DW'(count), '0);
        chk("mid_rst_csb0", DW'(csb0), 1);
        chk("mid_rst_csb1", DW'(csb1), 1);
        s_valid = 1;
        for (int i = 0; i < 5; i++) begin
            s_data = rnd128();
            step();
        end
        drain();

`ifdef SRAM_FIFO_FLUSH_EN
        // Flush with words queued and reads in flight
        m_ready = 0;
        s_valid = 1;
        for (int i = 0; i < 5; i++) begin
            s_data = rnd128();
            step();
        end
        s_valid = 0;
        flush = 1;
        #1;
        chk("flush_s_ready", DW'(s_ready), '0);
        chk("flush_csb1", DW'(csb1), 1);
        step();
        flush = 0;
        chk("flush_count", DW'(count), '0);
        m_ready = 1;
        repeat (3) begin
            step();
            chk("flush_no_data", DW'(m_valid), '0);
        end
        s_valid = 1;
        for (int i = 0; i < 4; i++) begin
            s_data = rnd128();
            step();
        end
        drain();
`endif

        // Random traffic: 500 words with 50% valid / ready
        p0 = pushed;
        n = 0;
        while (pushed - p0 < 500 && n < 5000) begin
            s_valid = $urandom_range(0, 1) == 1;
            m_ready = $urandom_range(0, 1) == 1;
            s_data  = rnd128();
            step();
            n++;
        end
        chk("random_pushed", DW'(pushed - p0 >= 500), 1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
